fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 142 ++++++++++++++
 tb/tb_fifo_rd_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : Read-side drain engine for a registered dual-clock FIFO. It
//            issues latency-aware reads and presents the words as a
//            valid/ready stream. The optional statistics outputs are enabled
//            by defining FIFO_RD_STREAM_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_stream #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter int RD_LAT    = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [AWIDTH-1:0] rd_usedw_i,
  input  logic              rd_full_i,
  input  logic              rd_empty_i,
  output logic              rd_req_o,
  input  logic [DWIDTH-1:0] q_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o
`ifdef FIFO_RD_STREAM_STAT_EN
  ,
  output logic [31:0]       word_cnt_o,
  output logic              ovf_o
`endif
);

  localparam int c_PW = $clog2(BUF_DEPTH);
  localparam int c_BW = $clog2(BUF_DEPTH + 1);
  localparam int c_SW = AWIDTH + $clog2(BUF_DEPTH + RD_LAT + 1) + 2;

  localparam logic [c_BW-1:0] c_FULL  = c_BW'(BUF_DEPTH);
  localparam logic [c_BW-1:0] c_BONE  = c_BW'(1);
  localparam logic [c_PW-1:0] c_PONE  = c_PW'(1);
  localparam logic [c_SW-1:0] c_DEPTH = c_SW'(BUF_DEPTH);

  logic              r_rd_req;
  logic [RD_LAT-1:0] r_req_sh;
  logic [DWIDTH-1:0] r_mem [BUF_DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_BW-1:0]   r_buf_cnt;

  logic [AWIDTH:0]   w_avail;
  logic [c_SW-1:0]   w_pend;
  logic [c_SW-1:0]   w_cnt_nxt;
  logic              w_tap;
  logic              w_pop;
  logic              w_valid;
  logic              w_issue;

  assign w_tap   = r_req_sh[RD_LAT-1];
  assign w_valid = (r_buf_cnt != '0);
  assign w_pop   = w_valid && ready_i;

  // w_pend counts the current request plus the older ones not yet returned,
  // i.e. every read the FIFO flags may not reflect yet. w_cnt_nxt is the
  // buffer occupancy the next request will see, so back-to-back reads
  // sustain full rate.
  always_comb begin
    w_avail = rd_full_i ? {1'b1, {AWIDTH{1'b0}}}
                        : (rd_empty_i ? '0 : {1'b0, rd_usedw_i});
    w_pend  = c_SW'(r_rd_req);
    for (int k = 0; k < RD_LAT - 1; k++) begin
      w_pend = w_pend + c_SW'(r_req_sh[k]);
    end
    w_cnt_nxt = c_SW'(r_buf_cnt) + c_SW'(w_tap) - c_SW'(w_pop);
    w_issue   = (c_SW'(w_avail) > w_pend) && ((w_cnt_nxt + w_pend) < c_DEPTH);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_rd_req  <= 1'b0;
      r_req_sh  <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_buf_cnt <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_rd_req <= w_issue;
      r_req_sh <= (r_req_sh << 1) | RD_LAT'(r_rd_req);
      if (w_tap) begin
        r_mem[r_wr_ptr] <= q_i;
        r_wr_ptr        <= r_wr_ptr + c_PONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PONE;
      end
      case ({w_tap, w_pop})
        2'b10:   r_buf_cnt <= r_buf_cnt + c_BONE;
        2'b01:   r_buf_cnt <= r_buf_cnt - c_BONE;
        default: r_buf_cnt <= r_buf_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i && w_tap) begin
      assert (r_buf_cnt != c_FULL)
        else $error("fifo_rd_stream: capture into a full output buffer");
    end
  end

  assign rd_req_o = r_rd_req;
  assign data_o   = r_mem[r_rd_ptr];
  assign valid_o  = w_valid;
  assign busy_o   = r_rd_req || (|r_req_sh) || w_valid;

`ifdef FIFO_RD_STREAM_STAT_EN
  logic [31:0] r_word_cnt;
  logic        r_ovf;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_word_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_pop) begin
        r_word_cnt <= r_word_cnt + 32'd1;
      end
      if (w_tap && (r_buf_cnt == c_FULL)) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign word_cnt_o = r_word_cnt;
  assign ovf_o      = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// Module   : tb_fifo_rd_stream
// Brief    : Directed self-checking bench for fifo_rd_stream with a small
//            registered-FIFO model (one-cycle flag lag, two-stage read data).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          srst_i = 1'b1;
  logic [AW-1:0] rd_usedw_i = '0;
  logic          rd_full_i = 1'b0;
  logic          rd_empty_i = 1'b1;
  logic          rd_req_o;
  logic [7:0]    q_i = '0;
  logic [7:0]    data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          busy_o;
`ifdef FIFO_RD_STREAM_STAT_EN
  logic [31:0]   word_cnt_o;
  logic          ovf_o;
`endif

  fifo_rd_stream #(
    .DWIDTH    (8),
    .AWIDTH    (AW),
    .RD_LAT    (2),
    .BUF_DEPTH (4)
  ) dut (
    .clk_i      (clk),
    .srst_i     (srst_i),
    .rd_usedw_i (rd_usedw_i),
    .rd_full_i  (rd_full_i),
    .rd_empty_i (rd_empty_i),
    .rd_req_o   (rd_req_o),
    .q_i        (q_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o)
`ifdef FIFO_RD_STREAM_STAT_EN
    ,
    .word_cnt_o (word_cnt_o),
    .ovf_o      (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] p0 = '0;
  logic [7:0] p1 = '0;
  bit         hold_v = 1'b0;
  logic [7:0] hold_d = '0;
  int         req_cnt = 0;
  int         beats = 0;
  int         wr_left = 0;
  int         cyc = 0;
  logic [7:0] wr_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
      else begin
        n_err++;
        $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
  endtask

  task automatic set_flags();
    int n = fifo_q.size();
    rd_usedw_i = AW'(n);
    rd_full_i  = (n == 16);
    rd_empty_i = (n == 0);
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + 8'(i));
      exp_q.push_back(base + 8'(i));
    end
    set_flags();
  endtask

  // One clock: sample DUT mid-cycle, then advance the FIFO model after the edge.
  task automatic tick();
    bit req_now;
    bit rst_now;
    if (rd_req_o === 1'b1) begin
      check("overread", 32'(fifo_q.size() != 0), 32'd1);
      req_cnt++;
    end
    if (hold_v) begin
      check("hold_valid", 32'(valid_o), 32'd1);
      check("hold_data", 32'(data_o), 32'(hold_d));
    end
    if (valid_o === 1'b1 && ready_i) begin
      check("beat_present", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("beat_data", 32'(data_o), 32'(exp_q.pop_front()));
      beats++;
    end
    hold_v  = (valid_o === 1'b1) && !ready_i;
    hold_d  = data_o;
    req_now = (rd_req_o === 1'b1);
    rst_now = srst_i;
    @(posedge clk);
    #1;
    p1 = p0;
    p0 = (req_now && fifo_q.size() != 0) ? fifo_q.pop_front() : 8'h00;
    q_i = p1;
    if (rst_now) fifo_q.delete();
    if (wr_left > 0 && fifo_q.size() < 16 && $urandom_range(0, 1) == 1) begin
      fifo_q.push_back(wr_word);
      exp_q.push_back(wr_word);
      wr_word++;
      wr_left--;
    end
    set_flags();
  endtask

  task automatic do_reset();
    srst_i  = 1'b1;
    ready_i = 1'b0;
    tick();
    srst_i  = 1'b0;
    exp_q.delete();
    hold_v  = 1'b0;
    req_cnt = 0;
    beats   = 0;
    wr_left = 0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_req", 32'(rd_req_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
`ifdef FIFO_RD_STREAM_STAT_EN
    check("rst_wcnt", word_cnt_o, 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
`endif

    // 16 words, ready high: latency RD_LAT+2, 15-beat burst, then drain
    ready_i = 1'b1;
    load(16, 8'h00);
    cyc = 0;
    while (valid_o !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("t1_latency", 32'(cyc), 32'd4);
    beats = 0;
    repeat (15) tick();
    check("t1_burst", 32'(beats), 32'd15);
    cyc = 0;
    while ((busy_o !== 1'b0 || exp_q.size() != 0) && cyc < 100) begin
      tick();
      cyc++;
    end
    check("t1_beats", 32'(beats), 32'd16);
    check("t1_reqs", 32'(req_cnt), 32'd16);
    check("t1_busy", 32'(busy_o), 32'd0);

    // 10 words under backpressure
    req_cnt = 0;
    beats   = 0;
    ready_i = 1'b0;
    load(10, 8'h20);
    repeat (20) tick();
    check("t2_stall_reqs", 32'(req_cnt), 32'd4);
    check("t2_valid", 32'(valid_o), 32'd1);
    check("t2_head", 32'(data_o), 32'h20);
    ready_i = 1'b1;
    cyc = 0;
    while ((busy_o !== 1'b0 || exp_q.size() != 0) && cyc < 100) begin
      tick();
      cyc++;
    end
    check("t2_beats", 32'(beats), 32'd10);
    check("t2_left", 32'(exp_q.size()), 32'd0);

    // Single word
    req_cnt = 0;
    beats   = 0;
    load(1, 8'h55);
    repeat (20) tick();
    check("t3_reqs", 32'(req_cnt), 32'd1);
    check("t3_beats", 32'(beats), 32'd1);
    check("t3_busy", 32'(busy_o), 32'd0);

    // Full FIFO: full flag with usedw wrapped to zero
    req_cnt = 0;
    beats   = 0;
    load(16, 8'hA0);
    cyc = 0;
    while ((busy_o !== 1'b0 || exp_q.size() != 0 || cyc == 0) && cyc < 100) begin
      tick();
      cyc++;
    end
    check("t4_reqs", 32'(req_cnt), 32'd16);
    check("t4_beats", 32'(beats), 32'd16);

    // 1000 words with random ready and concurrent writes
    do_reset();
    wr_word = 8'h00;
    wr_left = 1000;
    cyc = 0;
    while ((beats < 1000 || wr_left != 0 || busy_o !== 1'b0) && cyc < 20000) begin
      ready_i = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    check("t5_beats", 32'(beats), 32'd1000);
    check("t5_left", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_RD_STREAM_STAT_EN
    check("t5_wcnt", word_cnt_o, 32'd1000);
    check("t5_ovf", 32'(ovf_o), 32'd0);
`endif

    // Reset with reads in flight and words buffered
    do_reset();
    load(8, 8'h60);
    repeat (5) tick();
    check("t6_pre_valid", 32'(valid_o), 32'd1);
    check("t6_pre_busy", 32'(busy_o), 32'd1);
    do_reset();
    check("t6_valid", 32'(valid_o), 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_req", 32'(rd_req_o), 32'd0);
    check("t6_data", 32'(data_o), 32'd0);
    ready_i = 1'b1;
    repeat (8) tick();
    check("t6_late_valid", 32'(valid_o), 32'd0);
    check("t6_late_beats", 32'(beats), 32'd0);
    check("t6_late_reqs", 32'(req_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
